// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR read/write arbiter: memory command codes,
// controller state encoding and the address-advance helper.
package ddr_pkg;

    localparam int ADDR_W = 29;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READ     = 3'd3,
        ST_RD_DRAIN = 3'd4
    } ddr_state_t;

    // Next beat address; the 29-bit result wraps naturally modulo 2^29.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned      step);
        logic [31:0] w_step;
        w_step = step;
        return addr + w_step[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/ddr_rr_arb2.sv
// Two-way round-robin grant (write / read). The last-grant register makes the
// client that was not served most recently win a simultaneous request; after
// reset the write side has priority.
module ddr_rr_arb2 import ddr_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    // High when the most recent grant went to the write client.
    logic r_last_wr;

    // Combinational grant: a lone request wins, a tie goes to the other side of r_last_wr.
    always_comb begin
        o_gnt_wr = i_en & i_req_wr & (~i_req_rd | ~r_last_wr);
        o_gnt_rd = i_en & i_req_rd & (~i_req_wr |  r_last_wr);
    end

    // Remember who was served so the next tie flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_wr <= 1'b0;
        end else if (o_gnt_wr) begin
            r_last_wr <= 1'b1;
        end else if (o_gnt_rd) begin
            r_last_wr <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr_rw_arbiter.sv
// DDR user-interface arbiter: grants one of a write client and a read client at
// a time, issues their bursts beat by beat on the memory command port, and
// waits for every read to return before granting again so writes never overtake
// reads.
module ddr_rw_arbiter import ddr_pkg::*; #(
    parameter int unsigned ADDR_STEP = 8,
    parameter int          LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phy_init_done,

    input  logic              wr_req,
    input  logic [28:0]       wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [255:0]      wr_data,
    output logic              wr_data_rd,
    output logic              wr_ack,
    output logic              wr_done,

    input  logic              rd_req,
    input  logic [28:0]       rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_ack,
    output logic              rd_done,
    output logic [255:0]      rd_data,
    output logic              rd_data_valid,

    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [28:0]       app_addr,
    output logic [255:0]      app_data,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,

    input  logic [255:0]      mem_data,
    input  logic              mem_data_valid,

    output logic              busy
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    ddr_state_t         r_state;
    logic [28:0]        r_addr;
    logic [LEN_W-1:0]   r_remain;
    logic [LEN_W-1:0]   r_out_cnt;
    logic [2:0]         r_cmd;

    logic               w_idle;
    logic               w_gnt_wr;
    logic               w_gnt_rd;
    logic               w_app_en;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_rd_ret;
    logic               w_rd_final;
    logic [LEN_W-1:0]   w_out_next;

    assign w_idle = (r_state == ST_IDLE);

    ddr_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_idle),
        .i_req_wr (wr_req),
        .i_req_rd (rd_req),
        .o_gnt_wr (w_gnt_wr),
        .o_gnt_rd (w_gnt_rd)
    );

    // Beat-level handshakes; returns are only counted while a read transfer owns
    // the port, so data arriving after an aborted read is forwarded but ignored.
    always_comb begin
        w_app_en   = ((r_state == ST_WRITE) || (r_state == ST_READ)) && (r_remain != '0);
        w_wr_acc   = (r_state == ST_WRITE) && w_app_en && app_rdy && app_wdf_rdy;
        w_rd_acc   = (r_state == ST_READ) && w_app_en && app_rdy;
        w_rd_ret   = ((r_state == ST_READ) || (r_state == ST_RD_DRAIN)) &&
                     mem_data_valid && (r_out_cnt != '0);
        w_rd_final = (r_state == ST_RD_DRAIN) && w_rd_ret && (r_out_cnt == ONE);
    end

    // Outstanding-read count after this cycle; issue and return together cancel.
    always_comb begin
        w_out_next = r_out_cnt;
        if (w_rd_acc && !w_rd_ret) begin
            w_out_next = r_out_cnt + ONE;
        end else if (!w_rd_acc && w_rd_ret) begin
            w_out_next = r_out_cnt - ONE;
        end
    end

    // Controller FSM: latches the granted burst, walks the address and tracks reads in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_addr    <= '0;
            r_remain  <= '0;
            r_out_cnt <= '0;
            r_cmd     <= CMD_WR;
        end else begin
            r_out_cnt <= w_out_next;
            case (r_state)
                ST_INIT: begin
                    if (phy_init_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // Zero-length grants complete on the spot and leave the FSM idle.
                    if (w_gnt_wr && (wr_len != '0)) begin
                        r_state  <= ST_WRITE;
                        r_addr   <= wr_addr;
                        r_remain <= wr_len;
                        r_cmd    <= CMD_WR;
                    end else if (w_gnt_rd && (rd_len != '0)) begin
                        r_state  <= ST_READ;
                        r_addr   <= rd_addr;
                        r_remain <= rd_len;
                        r_cmd    <= CMD_RD;
                    end
                end
                ST_WRITE: begin
                    if (w_wr_acc) begin
                        r_addr   <= next_addr(r_addr, ADDR_STEP);
                        r_remain <= r_remain - ONE;
                        if (r_remain == ONE) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_READ: begin
                    if (w_rd_acc) begin
                        r_addr   <= next_addr(r_addr, ADDR_STEP);
                        r_remain <= r_remain - ONE;
                        if (r_remain == ONE) begin
                            r_state <= ST_RD_DRAIN;
                        end
                    end
                end
                ST_RD_DRAIN: begin
                    if (w_out_next == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Output port drive; write data is the client's fall-through word, read data passes straight through.
    always_comb begin
        app_en        = w_app_en;
        app_cmd       = r_cmd;
        app_addr      = r_addr;
        app_data      = wr_data;
        wr_data_rd    = w_wr_acc;
        wr_ack        = w_gnt_wr;
        rd_ack        = w_gnt_rd;
        wr_done       = (w_wr_acc && (r_remain == ONE)) || (w_gnt_wr && (wr_len == '0));
        rd_done       = w_rd_final || (w_gnt_rd && (rd_len == '0));
        rd_data       = mem_data;
        rd_data_valid = mem_data_valid;
        busy          = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_RD_DRAIN);
    end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Self-checking bench for ddr_rw_arbiter: directed scenarios plus randomized
// sessions compared against a transaction-level model (address lists, grant
// order by round-robin rule, completion counts and read-return timing).
module tb_ddr_rw_arbiter;
    import ddr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, phy_init_done;
    logic         wr_req, rd_req, wr_data_rd, wr_ack, wr_done, rd_ack, rd_done, rd_data_valid;
    logic [28:0]  wr_addr, rd_addr, app_addr;
    logic [15:0]  wr_len, rd_len;
    logic [255:0] wr_data, rd_data, app_data, mem_data;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_rdy, mem_data_valid, busy;

    ddr_rw_arbiter #(.ADDR_STEP(8), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .phy_init_done(phy_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
        .wr_data_rd(wr_data_rd), .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_done(rd_done), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .app_cmd(app_cmd), .app_en(app_en), .app_addr(app_addr), .app_data(app_data),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int mem_lat = 5;
    int rq[$];
    bit last_was_wr = 1'b0;

    // snapshot of one cycle, taken at the falling edge
    int          s_cyc;
    bit          s_app_en, s_wr_ack, s_rd_ack, s_wr_done, s_rd_done, s_valid, s_busy;
    bit          s_wr_acc, s_rd_acc, s_wr_data_rd;
    logic [28:0] s_addr;
    logic [2:0]  s_cmd;

    int stall_err = 0, pass_err = 0, pop_err = 0, data_err = 0;
    bit          p_stalled = 1'b0;
    logic [2:0]  p_cmd;
    logic [28:0] p_addr;
    logic [255:0] p_data;

    // session results
    int          g_order[$];
    logic [28:0] w_addrs[$], r_addrs[$];
    int          w_acc_c[$], r_valid_c[$];
    int          w_ack_c, r_ack_c, w_done_c, r_done_c, w_done_n, r_done_n, en_n, busy_n;
    bit          timed_out;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        s_cyc = cyc; s_app_en = app_en; s_wr_ack = wr_ack; s_rd_ack = rd_ack;
        s_wr_done = wr_done; s_rd_done = rd_done; s_valid = rd_data_valid; s_busy = busy;
        s_addr = app_addr; s_cmd = app_cmd; s_wr_data_rd = wr_data_rd;
        s_wr_acc = app_en && app_rdy && app_wdf_rdy && (app_cmd == CMD_WR);
        s_rd_acc = app_en && app_rdy && (app_cmd == CMD_RD);
        if (wr_data_rd !== s_wr_acc) pop_err++;
        if (s_wr_acc && (app_data !== wr_data)) data_err++;
        if ((rd_data_valid !== mem_data_valid) || (mem_data_valid && (rd_data !== mem_data))) pass_err++;
        if (p_stalled && (!app_en || (app_cmd !== p_cmd) || (app_addr !== p_addr) ||
                          ((p_cmd == CMD_WR) && (app_data !== p_data)))) stall_err++;
        p_stalled = app_en && !(s_wr_acc || s_rd_acc);
        p_cmd = app_cmd; p_addr = app_addr; p_data = app_data;
        if (s_rd_acc) rq.push_back(cyc + mem_lat);
        @(posedge clk); #1;
        cyc++;
        if (s_wr_acc) wr_data = rand256();
        mem_data_valid = 1'b0;
        if ((rq.size() > 0) && (rq[0] <= cyc)) begin
            void'(rq.pop_front());
            mem_data_valid = 1'b1;
            mem_data = rand256();
        end
        case (rdy_mode)
            0: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
            1: begin app_rdy = ((cyc % 2) == 0); app_wdf_rdy = 1'b1; end
            default: begin app_rdy = ($urandom_range(0, 3) != 0); app_wdf_rdy = ($urandom_range(0, 3) != 0); end
        endcase
    endtask

    task automatic apply_reset(input bit phy);
        rst_n = 1'b0; phy_init_done = phy; wr_req = 1'b0; rd_req = 1'b0;
        mem_data_valid = 1'b0; p_stalled = 1'b0; rq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_was_wr = 1'b0;
    endtask

    // Drives up to two concurrent requests and records what the DUT did.
    task automatic run_session(input bit do_wr, input bit do_rd, input logic [28:0] wa,
                               input logic [28:0] ra, input logic [15:0] wl,
                               input logic [15:0] rl, input int budget);
        bit fin = 1'b0;
        g_order.delete(); w_addrs.delete(); r_addrs.delete(); w_acc_c.delete(); r_valid_c.delete();
        w_ack_c = -1; r_ack_c = -1; w_done_c = -1; r_done_c = -1;
        w_done_n = 0; r_done_n = 0; en_n = 0; busy_n = 0;
        wr_addr = wa; wr_len = wl; rd_addr = ra; rd_len = rl;
        wr_req = do_wr; rd_req = do_rd;
        for (int i = 0; i < budget && !fin; i++) begin
            tick();
            if (s_wr_ack) begin g_order.push_back(0); w_ack_c = s_cyc; wr_req = 1'b0;
                wr_addr = 29'($urandom()); wr_len = 16'($urandom()); end
            if (s_rd_ack) begin g_order.push_back(1); r_ack_c = s_cyc; rd_req = 1'b0;
                rd_addr = 29'($urandom()); rd_len = 16'($urandom()); end
            if (s_wr_acc) begin w_addrs.push_back(s_addr); w_acc_c.push_back(s_cyc); end
            if (s_rd_acc) r_addrs.push_back(s_addr);
            if (s_wr_done) begin w_done_n++; w_done_c = s_cyc; end
            if (s_rd_done) begin r_done_n++; r_done_c = s_cyc; end
            if (s_valid) r_valid_c.push_back(s_cyc);
            if (s_app_en) en_n++;
            if (s_busy) busy_n++;
            if ((!do_wr || w_done_n > 0) && (!do_rd || r_done_n > 0) && !s_busy) fin = 1'b1;
        end
        timed_out = !fin;
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; phy_init_done = 1'b1; wr_req = 1'b1; wr_len = 16'd1; wr_addr = 29'h40;
        rd_req = 1'b1; rd_len = 16'd1; rd_addr = 29'h80;
        tick(); tick();
        checks++; if (s_app_en !== 1'b0) begin errors++; $display("FAIL reset_app_en: got %0b want 0", s_app_en); end
        checks++; if (s_wr_data_rd !== 1'b0) begin errors++; $display("FAIL reset_wr_data_rd: got %0b want 0", s_wr_data_rd); end
        checks++; if ({s_wr_ack, s_rd_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {s_wr_ack, s_rd_ack}); end
        checks++; if ({s_wr_done, s_rd_done} !== 2'b00) begin errors++; $display("FAIL reset_dones: got %b want 00", {s_wr_done, s_rd_done}); end
        checks++; if ({s_cmd, s_addr} !== 32'h0) begin errors++; $display("FAIL reset_cmd_addr: got %h want 0", {s_cmd, s_addr}); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", s_busy); end
        wr_req = 1'b0; rd_req = 1'b0; rq.delete(); p_stalled = 1'b0;
        rst_n = 1'b1; last_was_wr = 1'b0;
        tick(); tick();
    endtask

    task automatic test_init_wait();
        int en_cnt = 0, ack_cnt = 0, dn = 0;
        bit ack_early, ack_now;
        apply_reset(1'b0);
        wr_req = 1'b1; wr_addr = 29'h40; wr_len = 16'd1;
        for (int i = 0; i < 1000; i++) begin
            tick(); if (s_app_en) en_cnt++; if (s_wr_ack) ack_cnt++;
        end
        checks++; if (en_cnt != 0) begin errors++; $display("FAIL init_no_app_en: got %0d want 0", en_cnt); end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL init_no_ack: got %0d want 0", ack_cnt); end
        phy_init_done = 1'b1;
        tick(); ack_early = s_wr_ack;
        tick(); ack_now = s_wr_ack; wr_req = 1'b0;
        checks++; if (ack_early !== 1'b0) begin errors++; $display("FAIL init_ack_early: got %0b want 0", ack_early); end
        checks++; if (ack_now !== 1'b1) begin errors++; $display("FAIL init_ack_next: got %0b want 1", ack_now); end
        for (int i = 0; i < 10; i++) begin tick(); if (s_wr_done) dn++; end
        checks++; if (dn != 1) begin errors++; $display("FAIL init_write_done: got %0d want 1", dn); end
        last_was_wr = 1'b1;
    endtask

    task automatic test_write_basic();
        rdy_mode = 0;
        run_session(1'b1, 1'b0, 29'h100, 29'h0, 16'd4, 16'd0, 50);
        last_was_wr = 1'b1;
        checks++; if (timed_out) begin errors++; $display("FAIL wr4_timeout: got timeout want completion"); end
        checks++; if (w_addrs.size() != 4) begin errors++; $display("FAIL wr4_beats: got %0d want 4", w_addrs.size()); end
        for (int i = 0; i < w_addrs.size() && i < 4; i++) begin
            logic [28:0] e; e = 29'h100 + 29'(i * 8);
            checks++; if (w_addrs[i] !== e) begin errors++; $display("FAIL wr4_addr[%0d]: got %h want %h", i, w_addrs[i], e); end
            checks++; if (w_acc_c[i] != w_ack_c + 1 + i) begin errors++; $display("FAIL wr4_cycle[%0d]: got %0d want %0d", i, w_acc_c[i], w_ack_c + 1 + i); end
        end
        checks++; if (w_done_n != 1) begin errors++; $display("FAIL wr4_done_count: got %0d want 1", w_done_n); end
        checks++; if (w_done_c != w_ack_c + 4) begin errors++; $display("FAIL wr4_done_cycle: got %0d want %0d", w_done_c, w_ack_c + 4); end
        checks++; if (busy_n != 4) begin errors++; $display("FAIL wr4_busy_cycles: got %0d want 4", busy_n); end
    endtask

    task automatic test_round_robin();
        apply_reset(1'b1);
        rdy_mode = 0; mem_lat = 3;
        tick();
        for (int k = 0; k < 2; k++) begin
            run_session(1'b1, 1'b1, 29'h200, 29'h300, 16'd2, 16'd1, 80);
            checks++; if (timed_out) begin errors++; $display("FAIL rr%0d_timeout: got timeout want completion", k); end
            checks++; if (g_order.size() != 2) begin errors++; $display("FAIL rr%0d_grants: got %0d want 2", k, g_order.size()); end
            else begin
                checks++; if (g_order[0] != 0 || g_order[1] != 1) begin errors++;
                    $display("FAIL rr%0d_order: got %0d,%0d want 0,1 (0=write)", k, g_order[0], g_order[1]); end
            end
        end
        last_was_wr = 1'b0;
    endtask

    task automatic test_read_stall();
        bit exp_rd_first;
        rdy_mode = 1; mem_lat = 5;
        exp_rd_first = last_was_wr;
        run_session(1'b1, 1'b1, 29'h5000, 29'h7000, 16'd2, 16'd3, 150);
        last_was_wr = 1'b1;
        checks++; if (timed_out) begin errors++; $display("FAIL rdst_timeout: got timeout want completion"); end
        checks++; if (g_order.size() != 2 || g_order[0] != (exp_rd_first ? 1 : 0)) begin errors++;
            $display("FAIL rdst_first_grant: got size %0d want first=%0d", g_order.size(), exp_rd_first ? 1 : 0); end
        checks++; if (r_addrs.size() != 3) begin errors++; $display("FAIL rdst_cmds: got %0d want 3", r_addrs.size()); end
        for (int i = 0; i < r_addrs.size() && i < 3; i++) begin
            checks++; if (r_addrs[i] !== 29'h7000 + 29'(i * 8)) begin errors++;
                $display("FAIL rdst_addr[%0d]: got %h want %h", i, r_addrs[i], 29'h7000 + 29'(i * 8)); end
        end
        checks++; if (r_valid_c.size() < 3 || r_done_c != r_valid_c[2]) begin errors++;
            $display("FAIL rdst_done_on_third_valid: got cycle %0d, %0d valids", r_done_c, r_valid_c.size()); end
        checks++; if (r_done_n != 1) begin errors++; $display("FAIL rdst_done_count: got %0d want 1", r_done_n); end
        checks++; if (w_ack_c <= r_done_c) begin errors++; $display("FAIL rdst_write_waits: got wr_ack %0d rd_done %0d", w_ack_c, r_done_c); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL rdst_stable_stall: got %0d violations want 0", stall_err); end
    endtask

    task automatic test_wrap();
        rdy_mode = 0;
        run_session(1'b1, 1'b0, 29'h1FFFFFF8, 29'h0, 16'd2, 16'd0, 40);
        last_was_wr = 1'b1;
        checks++; if (w_addrs.size() != 2) begin errors++; $display("FAIL wrap_beats: got %0d want 2", w_addrs.size()); end
        else begin
            checks++; if (w_addrs[0] !== 29'h1FFFFFF8) begin errors++; $display("FAIL wrap_addr0: got %h want 1ffffff8", w_addrs[0]); end
            checks++; if (w_addrs[1] !== 29'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 0", w_addrs[1]); end
        end
    endtask

    task automatic test_len_zero();
        rdy_mode = 0;
        run_session(1'b1, 1'b0, 29'h900, 29'h0, 16'd0, 16'd0, 20);
        last_was_wr = 1'b1;
        checks++; if (w_done_n != 1 || w_done_c != w_ack_c) begin errors++;
            $display("FAIL len0_wr_done: got %0d dones at %0d, ack at %0d", w_done_n, w_done_c, w_ack_c); end
        checks++; if (en_n != 0 || busy_n != 0) begin errors++; $display("FAIL len0_wr_idle: got en %0d busy %0d want 0", en_n, busy_n); end
        run_session(1'b0, 1'b1, 29'h0, 29'hA00, 16'd0, 16'd0, 20);
        last_was_wr = 1'b0;
        checks++; if (r_done_n != 1 || r_done_c != r_ack_c) begin errors++;
            $display("FAIL len0_rd_done: got %0d dones at %0d, ack at %0d", r_done_n, r_done_c, r_ack_c); end
        checks++; if (en_n != 0 || busy_n != 0) begin errors++; $display("FAIL len0_rd_idle: got en %0d busy %0d want 0", en_n, busy_n); end
    endtask

    task automatic test_reset_mid();
        int acc = 0, dn = 0, ack2 = 0, en2 = 0, dn2 = 0, ack3 = 0, dn3 = 0;
        rdy_mode = 0;
        wr_req = 1'b1; wr_addr = 29'h800; wr_len = 16'd8;
        for (int i = 0; i < 30 && acc < 3; i++) begin
            tick(); if (s_wr_ack) wr_req = 1'b0; if (s_wr_acc) acc++; if (s_wr_done) dn++;
        end
        checks++; if (app_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre_en: got %0b want 1", app_en); end
        #2 rst_n = 1'b0; phy_init_done = 1'b0;
        #1;
        checks++; if (app_en !== 1'b0) begin errors++; $display("FAIL rstmid_en_drop: got %0b want 0", app_en); end
        p_stalled = 1'b0;
        repeat (3) begin tick(); if (s_wr_done) dn++; end
        rst_n = 1'b1; last_was_wr = 1'b0;
        wr_req = 1'b1; wr_addr = 29'h40; wr_len = 16'd1;
        for (int i = 0; i < 20; i++) begin tick(); if (s_wr_ack) ack2++; if (s_app_en) en2++; if (s_wr_done) dn2++; end
        checks++; if (dn != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", dn); end
        checks++; if (ack2 + en2 + dn2 != 0) begin errors++; $display("FAIL rstmid_init_hold: got ack %0d en %0d done %0d want 0", ack2, en2, dn2); end
        phy_init_done = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (s_wr_ack) begin ack3++; wr_req = 1'b0; end if (s_wr_done) dn3++; end
        last_was_wr = 1'b1;
        checks++; if (ack3 != 1 || dn3 != 1) begin errors++; $display("FAIL rstmid_recover: got ack %0d done %0d want 1/1", ack3, dn3); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            bit dw, dr; int exp_first;
            logic [28:0] wa, ra; logic [15:0] wl, rl;
            rdy_mode = 2; mem_lat = $urandom_range(1, 6);
            phy_init_done = $urandom_range(0, 1);
            dw = $urandom_range(0, 1); dr = dw ? $urandom_range(0, 1) : 1'b1;
            wa = ($urandom_range(0, 3) == 0) ? 29'h1FFFFFE0 : 29'($urandom());
            ra = 29'($urandom());
            wl = 16'($urandom_range(0, 6)); rl = 16'($urandom_range(0, 6));
            exp_first = (dw && dr) ? (last_was_wr ? 1 : 0) : (dw ? 0 : 1);
            run_session(dw, dr, wa, ra, wl, rl, 300);
            checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout: got timeout want completion", it); end
            checks++; if (g_order.size() != (dw + dr) || g_order[0] != exp_first) begin errors++;
                $display("FAIL rnd%0d_grant: got %0d grants first %0d want %0d first %0d", it, g_order.size(),
                         (g_order.size() > 0) ? g_order[0] : -1, dw + dr, exp_first); end
            last_was_wr = (dw && dr) ? (exp_first == 1) : dw;
            if (dw) begin
                checks++; if (w_addrs.size() != int'(wl) || w_done_n != 1) begin errors++;
                    $display("FAIL rnd%0d_wr_count: got %0d beats %0d dones want %0d/1", it, w_addrs.size(), w_done_n, wl); end
                for (int i = 0; i < w_addrs.size(); i++) begin
                    checks++; if (w_addrs[i] !== wa + 29'(i * 8)) begin errors++;
                        $display("FAIL rnd%0d_wr_addr[%0d]: got %h want %h", it, i, w_addrs[i], wa + 29'(i * 8)); end
                end
            end
            if (dr) begin
                checks++; if (r_addrs.size() != int'(rl) || r_done_n != 1) begin errors++;
                    $display("FAIL rnd%0d_rd_count: got %0d cmds %0d dones want %0d/1", it, r_addrs.size(), r_done_n, rl); end
                for (int i = 0; i < r_addrs.size(); i++) begin
                    checks++; if (r_addrs[i] !== ra + 29'(i * 8)) begin errors++;
                        $display("FAIL rnd%0d_rd_addr[%0d]: got %h want %h", it, i, r_addrs[i], ra + 29'(i * 8)); end
                end
                checks++; if ((rl == 0) ? (r_done_c != r_ack_c) : (r_valid_c.size() != int'(rl) || r_done_c != r_valid_c[rl-1])) begin
                    errors++; $display("FAIL rnd%0d_rd_done_time: got %0d (ack %0d, %0d valids)", it, r_done_c, r_ack_c, r_valid_c.size()); end
            end
            if (dw && dr) begin
                checks++; if ((exp_first == 0) ? (r_ack_c <= w_done_c) : (w_ack_c <= r_done_c)) begin errors++;
                    $display("FAIL rnd%0d_ordering: got acks %0d/%0d dones %0d/%0d", it, w_ack_c, r_ack_c, w_done_c, r_done_c); end
            end
        end
    endtask

    task automatic test_stream_integrity();
        checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stability: got %0d want 0", stall_err); end
        checks++; if (pass_err != 0) begin errors++; $display("FAIL read_passthrough: got %0d want 0", pass_err); end
        checks++; if (pop_err != 0) begin errors++; $display("FAIL wr_data_rd_match: got %0d want 0", pop_err); end
        checks++; if (data_err != 0) begin errors++; $display("FAIL app_data_match: got %0d want 0", data_err); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; phy_init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
        wr_data = rand256(); mem_data = '0; mem_data_valid = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        #1;
        test_reset();
        test_init_wait();
        test_write_basic();
        test_round_robin();
        test_wrap();
        test_read_stall();
        test_len_zero();
        test_reset_mid();
        test_random();
        test_stream_integrity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
